// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to the data address queue bytes
// in a small FIFO, and loads from the status address report FIFO/FSM state.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [7:0]  TX_DATA_ADDR = 8'hF0,
    parameter logic [7:0]  STATUS_ADDR  = 8'hF4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_Address_dw,
    input  logic [31:0] in_WriteData_dw,
    input  logic        in_MemWrite,
    input  logic        in_MemRead,
    output logic [31:0] o_ReadData_dw,
    output logic        o_Tx,
    output logic        o_TxBusy
);

    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  CNT_FULL  = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] head, tail;
    logic [3:0]    count;
    logic          overflow;

    state_t        state, state_nx;
    logic [15:0]   baud, baud_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shift, shift_nx;
    logic          tx, tx_nx;
    logic          pop;

    logic hit_data, hit_stat, full, empty, push, drop, baud_end;
    logic [31:0] status;

    assign hit_data = in_Address_dw[7:0] == TX_DATA_ADDR;
    assign hit_stat = in_Address_dw[7:0] == STATUS_ADDR;
    assign full     = count == CNT_FULL;
    assign empty    = count == 4'd0;
    // full comes from the registered count, so a push into a full FIFO is
    // dropped even when a pop happens on the same edge
    assign push     = in_MemWrite & hit_data & ~full;
    assign drop     = in_MemWrite & hit_data & full;
    assign baud_end = baud == BAUD_LAST;

    always_comb begin
        state_nx   = state;
        baud_nx    = baud + 16'd1;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        tx_nx      = tx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                baud_nx = 16'd0;
                if (!empty) begin
                    pop      = 1'b1;
                    shift_nx = mem[head];
                    tx_nx    = 1'b0;
                    state_nx = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_nx    = 16'd0;
                    bit_idx_nx = 3'd0;
                    tx_nx      = shift[0];
                    state_nx   = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_nx = 16'd0;
                    if (bit_idx == 3'd7) begin
                        tx_nx    = 1'b1;
                        state_nx = STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                        tx_nx      = shift[bit_idx + 3'd1];
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_nx = 16'd0;
                    // chain straight into the next start bit for zero-gap frames
                    if (!empty) begin
                        pop      = 1'b1;
                        shift_nx = mem[head];
                        tx_nx    = 1'b0;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud     <= 16'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            tx       <= 1'b1;
            head     <= '0;
            tail     <= '0;
            count    <= 4'd0;
            overflow <= 1'b0;
        end else begin
            state   <= state_nx;
            baud    <= baud_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
            tx      <= tx_nx;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (in_MemWrite && hit_stat)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[tail] <= in_WriteData_dw[7:0];
    end

    assign status        = {20'd0, count, 4'd0, overflow, state != IDLE, empty, full};
    assign o_ReadData_dw = (in_MemRead && hit_stat) ? status : 32'h0;
    assign o_Tx          = tx;
    assign o_TxBusy      = ~empty | (state != IDLE);

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the processor's data-memory bus, downstream of the EX/MEM pipeline register and alongside the data RAM in the MEM stage.
- Stores to the TX data address push the low byte into a small FIFO. An FSM serialises queued bytes as 8N1 frames on o_Tx.
- Loads from the status address return FIFO and transmitter state, so software can poll before writing.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit; legal range 2 to 65535.
- FIFO_DEPTH, 8, byte FIFO entries; legal values 2, 4 or 8.
- TX_DATA_ADDR, 8'hF0, address[7:0] of the TX data register (write-only).
- STATUS_ADDR, 8'hF4, address[7:0] of the status register (read; write clears overflow).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_Address_dw  input  32  byte address from the EX/MEM ALU result; only [7:0] is decoded
- in_WriteData_dw  input  32  store data; only [7:0] is used for TX
- in_MemWrite  input  1  store strobe, one cycle per store
- in_MemRead  input  1  load strobe
- o_ReadData_dw  output  32  load data (combinational)
- o_Tx  output  1  serial line, idle high
- o_TxBusy  output  1  high while the FIFO is non-empty or a frame is in progress

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-high, sampled on rising edge of clk.
- Reset values: o_Tx=1, FIFO empty (count=0, pointers 0), overflow=0, FSM=IDLE, baud counter=0, bit index=0, o_TxBusy=0. Reset asserted mid-frame aborts the frame; o_Tx is 1 at the next edge.
- Address decode:
  - hit_data = in_Address_dw[7:0]==TX_DATA_ADDR
  - hit_stat = in_Address_dw[7:0]==STATUS_ADDR
  - Bits [31:8] are ignored; top-level decode is external.
- Push: in_MemWrite & hit_data & !full writes in_WriteData_dw[7:0] at the tail on the rising edge.
- Overflow: in_MemWrite & hit_data & full drops the byte and sets sticky overflow.
- Overflow clear: in_MemWrite & hit_stat clears overflow (data ignored). Set has priority over clear when both happen in the same cycle (impossible with a single address, but specified).
- Read data:
  - o_ReadData_dw = status word when in_MemRead & hit_stat, else 32'h0.
  - Status word: [0] full, [1] empty, [2] FSM!=IDLE, [3] overflow, [11:8] count (0..FIFO_DEPTH), other bits 0.
  - Reads of TX_DATA_ADDR return 0.
- FIFO: circular buffer with wrap-around pointers; full = count==FIFO_DEPTH, empty = count==0. Simultaneous push and pop in one cycle: both take effect, count unchanged. Push into full while a pop occurs the same cycle is still dropped (full is evaluated from the registered count).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if !empty, pop head into shift register, clear baud counter, go to START; o_Tx<=0 on the same edge.
  - START: hold o_Tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0, o_Tx<=shift[0].
  - DATA: each bit held CLKS_PER_BIT cycles, LSB first. After bit 7 completes go to STOP, o_Tx<=1.
  - STOP: hold o_Tx=1 for CLKS_PER_BIT cycles. At the end, if !empty, pop and go directly to START (zero gap); else go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary. Width is 16 bits.
- Latency: a byte written at edge k into an empty FIFO with FSM IDLE drives o_Tx low at edge k+1. A frame is exactly 10*CLKS_PER_BIT cycles; back-to-back frames have no idle gap.
- o_TxBusy = !empty | (FSM!=IDLE), registered-equivalent (derived from registered state only).
- o_Tx is driven from a register only (glitch-free).

Test Plan:
- Single byte, CLKS_PER_BIT=4: after reset, store 0x55 to 0xF0.
  - o_Tx low 1 cycle after the write edge.
  - Bits 1,0,1,0,1,0,1,0 each 4 cycles, then stop high 4 cycles.
  - Frame length 40 cycles; o_TxBusy falls after the stop bit.
- Back-to-back: store 0xA5 then 0x0F on consecutive cycles.
  - Two contiguous 40-cycle frames with no idle between them; decoded bytes are 0xA5, 0x0F.
- Overflow, CLKS_PER_BIT=4, FIFO_DEPTH=8: issue 10 consecutive stores (0x01..0x0A) starting from empty.
  - Byte 0x01 is popped at the first edge, so 0x01..0x09 are accepted and 0x0A is dropped.
  - Status reads full=1, overflow=1, count=8.
  - Store to 0xF4 clears overflow.
  - Nine frames are transmitted, in order.
- Status read: with 3 bytes queued and the FSM idle-pending, load 0xF4 returns 32'h0000_0300 before the pop edge. A load from other addresses returns 0.
- Simultaneous push/pop: time a store to coincide with the STOP→START pop. Count is unchanged and no byte is lost or duplicated.
- Reset mid-frame: assert reset during DATA bit 3.
  - Next edge: o_Tx=1, status=32'h0000_0002, o_TxBusy=0.
  - No residual frame after reset releases.
